// File: rtl/vga_mode_ctrl.sv
// vga_mode_ctrl: debounced next/prev/auto display-mode sequencer, applied only at VSYNC frame boundaries
module vga_mode_ctrl #(
    parameter int NUM_MODES    = 5,
    parameter int INIT_MODE    = 0,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int AUTO_FRAMES  = 300,
    parameter bit VS_ACT_LOW   = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    input  logic       vga_vs,
    output logic [2:0] mode_sel,
    output logic       mode_chg,
    output logic       busy
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int FW = $clog2(AUTO_FRAMES + 1);
    localparam logic [2:0] LAST = 3'(NUM_MODES - 1);
    localparam logic [2:0] INIT = 3'(INIT_MODE);
    localparam logic [DW-1:0] DB_END = DW'(DEBOUNCE_CYC - 1);
    localparam logic [FW-1:0] AF_END = FW'(AUTO_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_APPLY} state_t;

    state_t state, state_nx;
    logic [1:0] sync1, sync2, deb, press;
    logic [DW-1:0] dcnt [2];
    logic [2:0] vs_s;
    logic frame_tick;
    logic [FW-1:0] fcnt;
    logic [2:0] target, t_inc, t_dec;
    logic nxt, prv, manual, auto_adv, diff;

    assign manual   = |press;
    assign nxt      = press[0] & ~press[1];
    assign prv      = press[1] & ~press[0];
    assign auto_adv = auto_en & frame_tick & (fcnt == AF_END) & ~manual;
    assign t_inc    = (target == LAST) ? 3'd0 : target + 3'd1;
    assign t_dec    = (target == 3'd0) ? LAST : target - 3'd1;
    assign diff     = target != mode_sel;
    assign busy     = state != S_IDLE;

    // Button synchronisers and debouncers; index 0 = next, 1 = prev
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= {btn_prev, btn_next};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_END) begin
                    dcnt[i]  <= '0;
                    deb[i]   <= sync2[i];
                    press[i] <= sync2[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    // VSYNC synchroniser with registered active-edge detect
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vs_s       <= '0;
            frame_tick <= 1'b0;
        end else begin
            vs_s       <= {vs_s[1:0], vga_vs};
            frame_tick <= VS_ACT_LOW ? (vs_s[2] & ~vs_s[1]) : (vs_s[1] & ~vs_s[2]);
        end
    end

    // Requested mode and slideshow frame counter; manual presses win over auto advance
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            target <= INIT;
            fcnt   <= '0;
        end else begin
            fcnt   <= (!auto_en || manual) ? '0 : !frame_tick ? fcnt : (fcnt == AF_END) ? '0 : fcnt + 1'b1;
            target <= (nxt || auto_adv) ? t_inc : prv ? t_dec : target;
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        state <= sys_rst ? S_IDLE : state_nx;
    end

    // FSM next state: wait for a frame boundary while a different target is pending
    always_comb begin
        state_nx = S_IDLE;
        state_nx = (state == S_IDLE) ? (diff ? S_PEND : S_IDLE) :
                   (state == S_PEND) ? (!diff ? S_IDLE : frame_tick ? S_APPLY : S_PEND) : S_IDLE;
    end

    // Commit the target at the close of S_APPLY and flag the change
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_sel <= INIT;
            mode_chg <= 1'b0;
        end else begin
            mode_chg <= (state == S_APPLY) && diff;
            if (state == S_APPLY) mode_sel <= target;
        end
    end
endmodule
